// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and its sequencing controller.
// The controller side (master) drives enables, flushes, halt and the counters.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             dmem_req_3;
    logic             ld_ex;
    logic [4:0]       ld_wsel_ex;
    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             use_rt_id;
    logic             branch_taken_3;
    logic             halt_4;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  ihit, dhit, dmem_req_3, ld_ex, ld_wsel_ex, rs_id, rt_id,
               use_rt_id, branch_taken_3, halt_4,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, halt, stall_cnt, flush_cnt
    );

    modport slave (
        output ihit, dhit, dmem_req_3, ld_ex, ld_wsel_ex, rs_id, rt_id,
               use_rt_id, branch_taken_3, halt_4,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage pipeline: latch enables/flushes for
// memory freezes, load-use bubbles, taken-branch flushes and halt.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipeline_ctrl_if.master      bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state;
    state_t           nextState;

    logic             advance;
    logic             hz;
    logic             pcEn;
    logic             ifidEn;
    logic             ifidFlush;
    logic             idexEn;
    logic             idexFlush;
    logic             exmemEn;
    logic             exmemFlush;
    logic             memwbEn;
    logic             stallEvt;
    logic             flushEvt;

    logic             haltQ;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        advance = bus.ihit & (~bus.dmem_req_3 | bus.dhit);
        // Register 0 is never a real dependency, so a load into it never stalls.
        hz = bus.ld_ex & (bus.ld_wsel_ex != 5'd0) &
             ((bus.ld_wsel_ex == bus.rs_id) |
              (bus.use_rt_id & (bus.ld_wsel_ex == bus.rt_id)));
    end

    always_comb begin
        nextState  = state;
        pcEn       = 1'b0;
        ifidEn     = 1'b0;
        ifidFlush  = 1'b0;
        idexEn     = 1'b0;
        idexFlush  = 1'b0;
        exmemEn    = 1'b0;
        exmemFlush = 1'b0;
        memwbEn    = 1'b0;
        stallEvt   = 1'b0;
        flushEvt   = 1'b0;

        if (RST) begin
            nextState  = RUN;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            exmemFlush = 1'b1;
        end else if (state == HALT) begin
            nextState = HALT;
        end else begin
            nextState = RUN;
            if (bus.halt_4) begin
                nextState = HALT;
            end else if (bus.dmem_req_3 & ~bus.dhit) begin
                nextState = DWAIT;
            end else if (bus.dmem_req_3 & bus.dhit & ~bus.ihit) begin
                // Retire the finished access into MEM/WB and bubble EX/MEM so it is not reissued.
                memwbEn    = 1'b1;
                exmemFlush = 1'b1;
            end else if (~advance) begin
                nextState = RUN;
            end else if (bus.branch_taken_3) begin
                pcEn       = 1'b1;
                ifidEn     = 1'b1;
                idexEn     = 1'b1;
                exmemEn    = 1'b1;
                memwbEn    = 1'b1;
                ifidFlush  = 1'b1;
                idexFlush  = 1'b1;
                exmemFlush = 1'b1;
                flushEvt   = 1'b1;
            end else if (hz) begin
                idexEn     = 1'b1;
                idexFlush  = 1'b1;
                exmemEn    = 1'b1;
                memwbEn    = 1'b1;
            end else begin
                pcEn    = 1'b1;
                ifidEn  = 1'b1;
                idexEn  = 1'b1;
                exmemEn = 1'b1;
                memwbEn = 1'b1;
            end
            stallEvt = ~pcEn;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= RUN;
            haltQ    <= 1'b0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            state <= nextState;
            haltQ <= (nextState == HALT);
            if (stallEvt) stallCnt <= satInc(stallCnt);
            if (flushEvt) flushCnt <= satInc(flushCnt);
        end
    end

    assign bus.pc_en       = pcEn;
    assign bus.ifid_en     = ifidEn;
    assign bus.ifid_flush  = ifidFlush;
    assign bus.idex_en     = idexEn;
    assign bus.idex_flush  = idexFlush;
    assign bus.exmem_en    = exmemEn;
    assign bus.exmem_flush = exmemFlush;
    assign bus.memwb_en    = memwbEn;
    assign bus.halt        = haltQ;
    assign bus.stall_cnt   = stallCnt;
    assign bus.flush_cnt   = flushCnt;

endmodule
